// File: rtl/truth_table_probe.sv
// truth_table_probe: scans all eight input vectors of a 3-input combinational
// block and records its output as an 8-bit truth-table code. Bit i of the code
// holds the output for vector i = {in1,in2,in3}.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             scan request, honoured only while idle
//   expected[7:0]     reference code, latched when a scan is accepted
//   probe_out         output of the block under characterization
//   probe_in1/2/3     vector driven into the block (in1 = MSB of index)
//   busy              scan in progress, including the completion cycle
//   done              one-cycle completion pulse
//   table_code[7:0]   last completed truth-table code (`table` is a reserved word)
//   table_valid       table_code holds a complete scan
//   match             table_code equals the latched reference code
module truth_table_probe #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] expected,
  input  logic       probe_out,
  output logic       probe_in1,
  output logic       probe_in2,
  output logic       probe_in3,
  output logic       busy,
  output logic       done,
  output logic [7:0] table_code,
  output logic       table_valid,
  output logic       match
);

  localparam int unsigned IDX_W = 3;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(7);

  // Reject parameter sets that cannot produce a well-formed scan.
  if (SETTLE_CYCLES == 0 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("truth_table_probe: SETTLE_CYCLES must be in 1..255");
  end
  if ((64'(1) << CNT_W) <= 64'(SETTLE_CYCLES)) begin : g_bad_cnt_w
    $error("truth_table_probe: CNT_W too narrow for SETTLE_CYCLES");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]       shadow_q, shadow_d;   // bit 7 is taken straight from probe_out
  logic [7:0]       exp_q, exp_d;
  logic [7:0]       table_q, table_d;
  logic             valid_q, valid_d;
  logic             match_q, match_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [7:0]       final_code;

  assign final_code = {probe_out, shadow_q};

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    exp_d    = exp_q;
    table_d  = table_q;
    valid_d  = valid_q;
    match_d  = match_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_SETTLE;
          idx_d    = '0;
          cnt_d    = RELOAD;
          shadow_d = '0;
          exp_d    = expected;
          valid_d  = 1'b0;
          match_d  = 1'b0;
        end
      end
      S_SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (idx_q != LAST_IDX) begin
          shadow_d[idx_q] = probe_out;
          idx_d           = idx_q + IDX_W'(1);
          cnt_d           = RELOAD;
        end else begin
          // Last vector: its sample goes straight into the published code.
          state_d = S_DONE;
          table_d = final_code;
          match_d = (final_code == exp_q);
          valid_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      exp_q    <= '0;
      table_q  <= '0;
      valid_q  <= 1'b0;
      match_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      exp_q    <= exp_d;
      table_q  <= table_d;
      valid_q  <= valid_d;
      match_q  <= match_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // The index register itself drives the probe vector.
  assign probe_in1   = idx_q[2];
  assign probe_in2   = idx_q[1];
  assign probe_in3   = idx_q[0];
  assign busy        = busy_q;
  assign done        = done_q;
  assign table_code  = table_q;
  assign table_valid = valid_q;
  assign match       = match_q;

endmodule

// File: tb/tb_truth_table_probe.sv
// Directed testbench for truth_table_probe: one instance with SETTLE_CYCLES=4
// probing a selectable logic function, one with SETTLE_CYCLES=1 probing a
// constant-1 output.
module tb_truth_table_probe;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_a, start_b;
  logic [7:0] exp_a, exp_b;
  logic       pout_a;
  logic       in1_a, in2_a, in3_a, busy_a, done_a, valid_a, match_a;
  logic [7:0] table_a;
  logic       in1_b, in2_b, in3_b, busy_b, done_b, valid_b, match_b;
  logic [7:0] table_b;
  logic [1:0] func_sel;
  logic [2:0] vec_a;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  truth_table_probe #(.SETTLE_CYCLES(4), .CNT_W(8)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .expected(exp_a), .probe_out(pout_a),
    .probe_in1(in1_a), .probe_in2(in2_a), .probe_in3(in3_a),
    .busy(busy_a), .done(done_a), .table_code(table_a),
    .table_valid(valid_a), .match(match_a)
  );

  truth_table_probe #(.SETTLE_CYCLES(1), .CNT_W(8)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .expected(exp_b), .probe_out(1'b1),
    .probe_in1(in1_b), .probe_in2(in2_b), .probe_in3(in3_b),
    .busy(busy_b), .done(done_b), .table_code(table_b),
    .table_valid(valid_b), .match(match_b)
  );

  assign vec_a = {in1_a, in2_a, in3_a};

  // Logic block under characterization: 0 -> in1&in2 | in2&in3, 1 -> in3, else 1.
  always_comb begin
    case (func_sel)
      2'd0:    pout_a = (in1_a & in2_a) | (in2_a & in3_a);
      2'd1:    pout_a = in3_a;
      default: pout_a = 1'b1;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [14:0] got;
    rst = 1'b1; start_a = 1'b1; start_b = 1'b1; exp_a = 8'hFF; exp_b = 8'hFF;
    step(); step();
    // start held together with rst must not launch a scan
    got = {busy_a, done_a, valid_a, match_a, vec_a, table_a};
    total_cnt++;
    if (got !== 15'h0) $display("FAIL reset_a got=%h want=%h", got, 15'h0);
    else pass_cnt++;
    got = {busy_b, done_b, valid_b, match_b, in1_b, in2_b, in3_b, table_b};
    total_cnt++;
    if (got !== 15'h0) $display("FAIL reset_b got=%h want=%h", got, 15'h0);
    else pass_cnt++;
    start_a = 1'b0; start_b = 1'b0;
    rst = 1'b0;
    step();
    total_cnt++;
    if (busy_a !== 1'b0) $display("FAIL reset_idle busy=%b want=0", busy_a);
    else pass_cnt++;
  endtask

  // Full scan on instance A; optionally pulses start mid-scan (must be ignored).
  task automatic run_scan_a(input logic [7:0] exp, input logic [7:0] want,
                            input logic want_match, input logic [7:0] old_tbl,
                            input logic pulse, input string name);
    logic [13:0] got, req;
    logic [14:0] got2, req2;
    start_a = 1'b1; exp_a = exp;
    step();
    start_a = 1'b0; exp_a = ~exp;   // latched value must not track the input
    for (int v = 0; v < 8; v++) begin
      for (int c = 0; c < 4; c++) begin
        start_a = (pulse && c == 1);
        got = {busy_a, done_a, valid_a, vec_a, table_a};
        req = {1'b1, 1'b0, 1'b0, 3'(v), old_tbl};
        total_cnt++;
        if (got !== req) $display("FAIL %s_v%0d_c%0d got=%h want=%h", name, v, c, got, req);
        else pass_cnt++;
        step();
      end
    end
    start_a = 1'b0;
    got2 = {busy_a, done_a, valid_a, match_a, vec_a, want};
    got2[7:0] = table_a;
    req2 = {1'b1, 1'b1, 1'b1, want_match, 3'b111, want};
    total_cnt++;
    if (got2 !== req2) $display("FAIL %s_done got=%h want=%h", name, got2, req2);
    else pass_cnt++;
    step();
    got2 = {busy_a, done_a, valid_a, match_a, vec_a, table_a};
    req2 = {1'b0, 1'b0, 1'b1, want_match, 3'b111, want};
    total_cnt++;
    if (got2 !== req2) $display("FAIL %s_after got=%h want=%h", name, got2, req2);
    else pass_cnt++;
  endtask

  task automatic test_match();
    func_sel = 2'd0;
    run_scan_a(8'hC8, 8'hC8, 1'b1, 8'h00, 1'b0, "scan_c8");
  endtask

  task automatic test_mismatch();
    func_sel = 2'd0;
    run_scan_a(8'hC9, 8'hC8, 1'b0, 8'hC8, 1'b0, "scan_c9");
  endtask

  task automatic test_ignore_start();
    func_sel = 2'd1;
    run_scan_a(8'hAA, 8'hAA, 1'b1, 8'hC8, 1'b1, "scan_aa");
  endtask

  task automatic test_abort();
    logic [14:0] got;
    int n;
    func_sel = 2'd0;
    start_a = 1'b1; exp_a = 8'hC8;
    step();
    start_a = 1'b0;
    n = 0;
    while (vec_a != 3'd5 && n < 40) begin
      step();
      n++;
    end
    total_cnt++;
    if (vec_a !== 3'd5) $display("FAIL abort_reach_v5 vec=%0d want=5", vec_a);
    else pass_cnt++;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    got = {busy_a, done_a, valid_a, match_a, vec_a, table_a};
    total_cnt++;
    if (got !== 15'h0) $display("FAIL abort_reset got=%h want=%h", got, 15'h0);
    else pass_cnt++;
    step(); step(); step();
    got = {busy_a, done_a, valid_a, match_a, vec_a, table_a};
    total_cnt++;
    if (got !== 15'h0) $display("FAIL abort_idle got=%h want=%h", got, 15'h0);
    else pass_cnt++;
    run_scan_a(8'hC8, 8'hC8, 1'b1, 8'h00, 1'b0, "scan_clean");
  endtask

  task automatic test_back_to_back();
    int done_at[$];
    func_sel = 2'd0;
    exp_a = 8'hC8;
    start_a = 1'b1;
    for (int n = 1; n <= 105; n++) begin
      step();
      if (done_a === 1'b1) done_at.push_back(n);
    end
    start_a = 1'b0;
    total_cnt++;
    if (done_at.size() != 3) $display("FAIL b2b_count got=%0d want=3", done_at.size());
    else pass_cnt++;
    if (done_at.size() == 3) begin
      total_cnt++;
      if (done_at[0] != 33) $display("FAIL b2b_first got=%0d want=33", done_at[0]);
      else pass_cnt++;
      total_cnt++;
      if (done_at[1] - done_at[0] != 34) $display("FAIL b2b_period1 got=%0d want=34", done_at[1] - done_at[0]);
      else pass_cnt++;
      total_cnt++;
      if (done_at[2] - done_at[1] != 34) $display("FAIL b2b_period2 got=%0d want=34", done_at[2] - done_at[1]);
      else pass_cnt++;
    end
    for (int n = 0; n < 40; n++) step();
    total_cnt++;
    if (busy_a !== 1'b0) $display("FAIL b2b_idle busy=%b want=0", busy_a);
    else pass_cnt++;
  endtask

  task automatic test_settle_one();
    int busy_cnt, done_at;
    logic [9:0] got;
    start_b = 1'b1; exp_b = 8'hFF;
    step();
    start_b = 1'b0;
    busy_cnt = 0; done_at = 0;
    for (int n = 1; n <= 15; n++) begin
      if (busy_b === 1'b1) busy_cnt++;
      if (done_b === 1'b1 && done_at == 0) done_at = n;
      if (n == 9) begin
        got = {valid_b, match_b, table_b};
        total_cnt++;
        if (got !== 10'h3FF) $display("FAIL s1_table got=%h want=%h", got, 10'h3FF);
        else pass_cnt++;
      end
      step();
    end
    total_cnt++;
    if (done_at != 9) $display("FAIL s1_done_at got=%0d want=9", done_at);
    else pass_cnt++;
    total_cnt++;
    if (busy_cnt != 9) $display("FAIL s1_busy_len got=%0d want=9", busy_cnt);
    else pass_cnt++;
  endtask

  initial begin
    rst = 1'b0; start_a = 1'b0; start_b = 1'b0;
    exp_a = 8'h00; exp_b = 8'h00; func_sel = 2'd0;
    test_reset();
    test_match();
    test_mismatch();
    test_ignore_start();
    test_abort();
    test_back_to_back();
    test_settle_one();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", pass_cnt, total_cnt);
    $fatal(1);
  end

endmodule

// File: doc/truth_table_probe.md
# truth_table_probe

Sequential characterizer for 3-input combinational logic blocks. On `start` it drives all eight input vectors {in1,in2,in3} = 000…111 into a device under test, waits a programmable settle time per vector and samples the DUT's single output. It then assembles the 8-bit truth-table code, with bit i holding the output for input vector i. It sits beside the synthesized gate-level logic modules and reads back the function they implement, for self-check and comparison against an expected code.

## Interface

Parameters:
- `SETTLE_CYCLES`, default 4: cycles each vector is held before sampling. Legal range 1..255; 0 is illegal and must fail elaboration.
- `CNT_W`, default 8: width of the settle counter. Must satisfy 2^CNT_W > SETTLE_CYCLES.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  scan request. Sampled only in IDLE.
- `expected`  in  8  expected truth-table code. Sampled on the cycle `start` is accepted.
- `probe_out`  in  1  DUT output. Must be synchronous to `clk` or settled within `SETTLE_CYCLES`.
- `probe_in1`  out  1  DUT input in1, MSB of the vector index.
- `probe_in2`  out  1  DUT input in2.
- `probe_in3`  out  1  DUT input in3, LSB of the vector index.
- `busy`  out  1  high from start acceptance through the DONE cycle.
- `done`  out  1  single-cycle completion pulse.
- `table`  out  8  last completed truth-table code.
- `table_valid`  out  1  `table` holds a complete scan; held until the next accepted start.
- `match`  out  1  `table` == latched `expected`; meaningful only while `table_valid`=1.

## Operation

- States:
  - IDLE: waits for `start`.
  - SETTLE: drives the current vector and counts settle cycles.
  - DONE: one cycle; asserts `done`.
- IDLE → SETTLE on `start`=1. Actions on that edge:
  - idx=0 and probe vector = 000.
  - settle counter = SETTLE_CYCLES-1.
  - shadow register = 0.
  - `expected` latched.
  - `table_valid` and `match` cleared.
- SETTLE with counter≠0: decrement the counter.
- SETTLE with counter=0: shadow[idx] ← `probe_out`. Then:
  - if idx<7: idx++, probe vector ← idx+1, counter reloaded, stay in SETTLE.
  - if idx=7: go to DONE.
- DONE, on entry edge:
  - `table` ← shadow with bit 7 = `probe_out`.
  - `match` ← (that value == latched `expected`).
  - `table_valid` ← 1.
  - `done`=1 for this one cycle. Next state is IDLE.
- Probe outputs {probe_in1,probe_in2,probe_in3} equal idx[2:0] throughout SETTLE. In DONE and IDLE they hold the last driven vector, 111 after a full scan.
- `start` in SETTLE or DONE is ignored. No queuing.
- `table` updates only on DONE entry. An aborted scan never alters it except through reset.
- idx is a 3-bit counter and never wraps during a scan: the idx=7 sample always exits to DONE.
- Reset, any state: returns to IDLE and clears idx, counter and shadow. Forces every output to its reset value.

## Timing

- Reset values: `probe_in1/2/3`=0, `busy`=0, `done`=0, `table`=8'h00, `table_valid`=0, `match`=0.
- `start` high at edge k accepted → vector 000 visible from cycle k+1; `busy`=1 from cycle k+1.
- Each vector is driven for exactly SETTLE_CYCLES cycles. `probe_out` is sampled on the last of them.
- `done`, `table_valid` and the new `table` are visible at cycle k+1+8·SETTLE_CYCLES. `busy` drops one cycle later.
- Earliest next accepted `start` is at edge k+2+8·SETTLE_CYCLES, which gives a period of 8·SETTLE_CYCLES+2 cycles.
- `rst` and `start` high together: `rst` wins; the block stays in IDLE.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan

- DUT model f = in1·in2 + in2·in3 (code 8'hC8), `expected`=8'hC8, SETTLE_CYCLES=4:
  - probe vectors step 000→111, 4 cycles each;
  - `done` pulse at k+33;
  - `table`=8'hC8, `match`=1, `table_valid`=1.
- Same DUT, `expected`=8'hC9 → `table`=8'hC8, `match`=0.
- SETTLE_CYCLES=1, DUT = constant 1 → `table`=8'hFF, `done` at k+9, `busy` high for exactly 9 cycles.
- Complete a scan (table 8'hC8), then start a scan with DUT = in3 (8'hAA) and pulse `start` repeatedly mid-scan:
  - the extra starts are ignored;
  - `table_valid`=0 during the scan;
  - `table` holds 8'hC8 until `done`, then reads 8'hAA.
- Assert `rst` during vector 5 of a scan → next cycle all outputs at reset values and state IDLE. A following `start` performs a full clean scan.
- `start` held high continuously → back-to-back scans with period 8·SETTLE_CYCLES+2, one `done` pulse per scan.
